// File: rtl/window_serializer_pkg.sv
// Shared types and sizing helpers for the window serializer.
// WINDOW_SERIALIZER_SUM_EN (see window_serializer.sv) widens the bus with a running sum.
package window_serializer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_SIZE  = 25;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

    // Width that holds the sum of SIZE unsigned WIDTH-bit elements.
    function automatic int unsigned sum_width(input int unsigned width, input int unsigned size);
        return width + $clog2(size + 1);
    endfunction

endpackage

// File: rtl/window_serializer_if.sv
// Parallel-load / serial-stream bus of the window serializer.
// WINDOW_SERIALIZER_SUM_EN adds o_sum and o_sum_valid.
interface window_serializer_if
    import window_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SIZE  = DEF_SIZE
);
    localparam int unsigned IDX_W = idx_width(SIZE);

    logic             i_load;
    logic [WIDTH-1:0] i_din [SIZE-1:0];
    logic             o_load_ready;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_dout;
    logic [IDX_W-1:0] o_idx;
    logic             o_last;
`ifdef WINDOW_SERIALIZER_SUM_EN
    localparam int unsigned SUM_W = sum_width(WIDTH, SIZE);
    logic [SUM_W-1:0] o_sum;
    logic             o_sum_valid;
`endif

`ifdef WINDOW_SERIALIZER_SUM_EN
    modport master (
        output i_load, i_din, i_ready,
        input  o_load_ready, o_valid, o_dout, o_idx, o_last, o_sum, o_sum_valid
    );
    modport slave (
        input  i_load, i_din, i_ready,
        output o_load_ready, o_valid, o_dout, o_idx, o_last, o_sum, o_sum_valid
    );
`else
    modport master (
        output i_load, i_din, i_ready,
        input  o_load_ready, o_valid, o_dout, o_idx, o_last
    );
    modport slave (
        input  i_load, i_din, i_ready,
        output o_load_ready, o_valid, o_dout, o_idx, o_last
    );
`endif

endinterface

// File: rtl/window_serializer.sv
// Captures a SIZE-element window in one cycle and streams it out one element per handshake.
// Optional feature macro: WINDOW_SERIALIZER_SUM_EN (running sum of accepted beats).
module window_serializer
    import window_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SIZE  = DEF_SIZE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    window_serializer_if.slave bus
);
    localparam int unsigned      IDX_W    = idx_width(SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shadow [SIZE-1:0];
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_idx_inc;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_capture;

    assign w_idx_inc = r_idx + IDX_W'(1);

    // State and registered beat outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dout  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dout  <= w_dout_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state; the beat registers are preloaded so o_dout always equals shadow[o_idx].
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dout_nxt  = r_dout;
        w_last_nxt  = r_last;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_load) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                    w_dout_nxt  = bus.i_din[0];
                    w_last_nxt  = 1'b0;
                end
            end
            SEND: begin
                if (bus.i_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                        w_dout_nxt  = '0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_dout_nxt  = r_shadow[w_idx_inc];
                        w_last_nxt  = (w_idx_inc == LAST_IDX);
                    end
                end
            end
        endcase
    end

    // Shadow copy of the window; frozen while streaming.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_capture) begin
            r_shadow <= bus.i_din;
        end
    end

    assign bus.o_load_ready = (r_state == IDLE);
    assign bus.o_valid      = (r_state == SEND);
    assign bus.o_dout       = r_dout;
    assign bus.o_idx        = r_idx;
    assign bus.o_last       = r_last;

`ifdef WINDOW_SERIALIZER_SUM_EN
    localparam int unsigned SUM_W = sum_width(WIDTH, SIZE);

    logic [SUM_W-1:0] r_sum;
    logic             r_sum_valid;
    logic             w_hs;

    assign w_hs = (r_state == SEND) && bus.i_ready;

    // Running sum of accepted beats; pulse marks the completed window total.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= w_hs && (r_idx == LAST_IDX);
            if (w_capture) begin
                r_sum <= '0;
            end else if (w_hs) begin
                r_sum <= r_sum + SUM_W'(r_dout);
            end
        end
    end

    assign bus.o_sum       = r_sum;
    assign bus.o_sum_valid = r_sum_valid;
`endif

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer: vector table plus scoreboarded beat stream.
// Builds with or without WINDOW_SERIALIZER_SUM_EN.
module tb_window_serializer;
    import window_serializer_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 25;
    localparam int unsigned IW = idx_width(N);
    localparam int          NV = 5;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct {
        int base;
        int step;
        int mode;
        int exp_first;
        int exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    window_serializer_if #(.WIDTH(W), .SIZE(N)) bus ();
    window_serializer_if #(.WIDTH(W), .SIZE(2)) bus2 ();

    window_serializer #(.WIDTH(W), .SIZE(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    window_serializer #(.WIDTH(W), .SIZE(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       exp_q[$];
    beat_t       mon_b;
    vec_t        vecs[NV];
    int          ready_mode = 0;
    logic [3:0]  ready_pat  = 4'b1001;
    logic [1:0]  rcnt       = 2'd0;
    logic        cap_pending = 1'b0;
    logic        prev_stall  = 1'b0;
    logic [W-1:0]  prev_dout;
    logic [IW-1:0] prev_idx;
    logic        sum_pending = 1'b0;
    logic [63:0] exp_sum     = '0;
    int          obs_first   = -1;
    int          obs_last    = -1;
    int          n_beats     = 0;
    int          n_caps      = 0;
    logic        gap_en      = 1'b0;
    logic        saw_window  = 1'b0;
    int          idle_run    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready: always, 1-0-0-1 pattern, or random.
    always @(posedge clk) begin
        #1;
        rcnt = rcnt + 2'd1;
        case (ready_mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = ready_pat[rcnt];
            default: bus.i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cap_pending = 1'b0;
            prev_stall  = 1'b0;
            sum_pending = 1'b0;
        end else begin
`ifdef WINDOW_SERIALIZER_SUM_EN
            check("sum_valid_pulse", 64'(bus.o_sum_valid), 64'(sum_pending));
            if (sum_pending) check("sum_value", 64'(bus.o_sum), exp_sum);
`endif
            sum_pending = 1'b0;
            if (cap_pending) begin
                check("first_valid_latency", 64'(bus.o_valid), 64'(1));
                check("first_idx", 64'(bus.o_idx), 64'(0));
            end
            cap_pending = 1'b0;
            if (prev_stall) begin
                check("stall_valid", 64'(bus.o_valid), 64'(1));
                check("stall_dout", 64'(bus.o_dout), 64'(prev_dout));
                check("stall_idx", 64'(bus.o_idx), 64'(prev_idx));
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_dout  = bus.o_dout;
            prev_idx   = bus.o_idx;
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_dout", 64'(bus.o_dout), 64'(mon_b.data));
                    check("beat_idx", 64'(bus.o_idx), 64'(mon_b.idx));
                    check("beat_last", 64'(bus.o_last), 64'(mon_b.last));
                    if (mon_b.idx == '0) obs_first = int'(bus.o_dout);
                    if (mon_b.last) begin
                        obs_last    = int'(bus.o_dout);
                        sum_pending = 1'b1;
                    end
                    exp_sum = exp_sum + 64'(mon_b.data);
                    n_beats++;
                end
            end
            if (bus.o_valid) begin
                if (gap_en && saw_window && idle_run != 0) check("idle_gap", 64'(idle_run), 64'(1));
                idle_run   = 0;
                saw_window = 1'b1;
            end else begin
                idle_run++;
            end
            if (bus.i_load && bus.o_load_ready) begin
                for (int k = 0; k < int'(N); k++) begin
                    mon_b.data = bus.i_din[k];
                    mon_b.idx  = IW'(k);
                    mon_b.last = (k == int'(N) - 1);
                    exp_q.push_back(mon_b);
                end
                cap_pending = 1'b1;
                exp_sum     = '0;
                n_caps++;
            end
        end
    end

    // Load one window, then wait (bounded) until the block is idle again.
    task automatic run_window(input int base, input int step, output int lat);
        int c;
        obs_first = -1;
        obs_last  = -1;
        for (int k = 0; k < int'(N); k++) bus.i_din[k] = W'(base + step * k);
        bus.i_load = 1'b1;
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        for (c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (bus.o_load_ready) break;
        end
        lat = c;
        check("window_done_in_time", 64'(c <= 2000), 64'(1));
        check("window_drained", 64'(exp_q.size()), 64'(0));
        check("idle_valid", 64'(bus.o_valid), 64'(0));
        check("idle_dout", 64'(bus.o_dout), 64'(0));
        check("idle_idx", 64'(bus.o_idx), 64'(0));
        check("idle_last", 64'(bus.o_last), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int caps0;
        int beats0;
        int c;

        vecs[0] = '{base: 1,   step: 1, mode: 0, exp_first: 1,   exp_last: 25};
        vecs[1] = '{base: 1,   step: 1, mode: 1, exp_first: 1,   exp_last: 25};
        vecs[2] = '{base: 255, step: 0, mode: 2, exp_first: 255, exp_last: 255};
        vecs[3] = '{base: 10,  step: 7, mode: 2, exp_first: 10,  exp_last: 178};
        vecs[4] = '{base: 200, step: 3, mode: 1, exp_first: 200, exp_last: 16};

        rst         = 1'b1;
        bus.i_load  = 1'b0;
        bus.i_ready = 1'b0;
        for (int k = 0; k < int'(N); k++) bus.i_din[k] = '0;
        bus2.i_load  = 1'b0;
        bus2.i_ready = 1'b1;
        bus2.i_din[0] = '0;
        bus2.i_din[1] = '0;
        #1;
        check("rst_load_ready", 64'(bus.o_load_ready), 64'(1));
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_dout", 64'(bus.o_dout), 64'(0));
        check("rst_idx", 64'(bus.o_idx), 64'(0));
        check("rst_last", 64'(bus.o_last), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven windows under different ready patterns.
        for (int v = 0; v < NV; v++) begin
            ready_mode = vecs[v].mode;
            @(posedge clk); #1;
            run_window(vecs[v].base, vecs[v].step, lat);
            if (vecs[v].mode == 0) check("load_ready_latency", 64'(lat), 64'(N));
            check("first_elem", 64'(obs_first), 64'(vecs[v].exp_first));
            check("last_elem", 64'(obs_last), 64'(vecs[v].exp_last));
        end

        // Load held high with changing data: back-to-back windows, one idle cycle apart.
        ready_mode = 0;
        @(posedge clk); #1;
        gap_en     = 1'b1;
        saw_window = 1'b0;
        idle_run   = 0;
        caps0      = n_caps;
        for (int k = 0; k < int'(N); k++) bus.i_din[k] = W'($urandom);
        bus.i_load = 1'b1;
        for (int i = 0; i < 3 * (int'(N) + 1); i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < int'(N); k++) bus.i_din[k] = W'($urandom);
            if (i == 3 * (int'(N) + 1) - 1) bus.i_load = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("b2b_windows", 64'(n_caps - caps0), 64'(3));
        check("b2b_drained", 64'(exp_q.size()), 64'(0));
        gap_en = 1'b0;

        // Reset in the middle of a window.
        beats0 = n_beats;
        for (int k = 0; k < int'(N); k++) bus.i_din[k] = W'(50 + k);
        bus.i_load = 1'b1;
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        for (c = 0; c < 200; c++) begin
            if (n_beats - beats0 >= 10) break;
            @(posedge clk); #1;
        end
        check("mid_window_beats", 64'(n_beats - beats0), 64'(10));
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.o_valid), 64'(0));
        check("rst_async_last", 64'(bus.o_last), 64'(0));
        check("rst_async_load_ready", 64'(bus.o_load_ready), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_load_ready", 64'(bus.o_load_ready), 64'(1));
        check("post_rst_idx", 64'(bus.o_idx), 64'(0));
        check("post_rst_dout", 64'(bus.o_dout), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_beats", 64'(bus.o_valid), 64'(0));
        end
        run_window(60, 2, lat);
        check("post_rst_latency", 64'(lat), 64'(N));
        check("post_rst_first", 64'(obs_first), 64'(60));
        check("post_rst_last", 64'(obs_last), 64'(108));

`ifdef WINDOW_SERIALIZER_SUM_EN
        // Full-scale window: sum must not overflow.
        run_window(255, 0, lat);
        check("sum_full_scale", 64'(bus.o_sum), 64'(6375));
        @(posedge clk); #1;
        check("sum_valid_single", 64'(bus.o_sum_valid), 64'(0));
        check("sum_hold", 64'(bus.o_sum), 64'(6375));
`endif

        // Minimum window size.
        bus2.i_din[0] = W'(3);
        bus2.i_din[1] = W'(7);
        bus2.i_load   = 1'b1;
        @(posedge clk); #1;
        bus2.i_load   = 1'b0;
        check("s2_beat0_valid", 64'(bus2.o_valid), 64'(1));
        check("s2_beat0_dout", 64'(bus2.o_dout), 64'(3));
        check("s2_beat0_idx", 64'(bus2.o_idx), 64'(0));
        check("s2_beat0_last", 64'(bus2.o_last), 64'(0));
        @(posedge clk); #1;
        check("s2_beat1_dout", 64'(bus2.o_dout), 64'(7));
        check("s2_beat1_idx", 64'(bus2.o_idx), 64'(1));
        check("s2_beat1_last", 64'(bus2.o_last), 64'(1));
        @(posedge clk); #1;
        check("s2_idle_valid", 64'(bus2.o_valid), 64'(0));
        check("s2_idle_load_ready", 64'(bus2.o_load_ready), 64'(1));
        check("s2_idle_dout", 64'(bus2.o_dout), 64'(0));
`ifdef WINDOW_SERIALIZER_SUM_EN
        check("s2_sum_valid", 64'(bus2.o_sum_valid), 64'(1));
        check("s2_sum", 64'(bus2.o_sum), 64'(10));
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
